// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, ALU, branch target and EX/MEM register.
// Define EX_MUL_EN to build the iterative radix-2 multiplier (alu_op 10).
module ex_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int REG_AW    = 5,
    parameter int IMM_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        ctl_in,
    input  logic [3:0]        alu_op,
    input  logic              alu_src,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        ctl_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [XLEN-1:0]   alu_result_out,
    output logic              zero_out,
    output logic [PC_W-1:0]   pc_imm_out,
    output logic [XLEN-1:0]   store_data_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              busy,
    output logic              dbg_state
);
    localparam int SH_W = $clog2(XLEN);

    // Handshake: an op transfers on any edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge.
    logic [XLEN-1:0]   w_op_a, w_op_b_fwd, w_op_b, w_alu;
    logic [PC_W-1:0]   w_pc_imm;
    logic [SH_W-1:0]   w_shamt;
    logic              w_accept, w_busy, w_ld;
    logic [6:0]        w_ld_ctl;
    logic [REG_AW-1:0] w_ld_rd;
    logic [XLEN-1:0]   w_ld_result, w_ld_store;
    logic [PC_W-1:0]   w_ld_pc, w_ld_pc_imm;

    logic              r_out_valid, r_zero;
    logic [6:0]        r_ctl;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_result, r_store;
    logic [PC_W-1:0]   r_pc, r_pc_imm;

    always_comb begin
        w_op_a = rs1_data;
        if (fwd_a == 2'b10)      w_op_a = mem_data;
        else if (fwd_a == 2'b01) w_op_a = wb_data;
        w_op_b_fwd = rs2_data;
        if (fwd_b == 2'b10)      w_op_b_fwd = mem_data;
        else if (fwd_b == 2'b01) w_op_b_fwd = wb_data;
        w_op_b = alu_src ? imm_in : w_op_b_fwd;
    end

    assign w_shamt  = w_op_b[SH_W-1:0];
    assign w_pc_imm = pc_in + (PC_W'($signed(imm_in)) << IMM_SHIFT);

    always_comb begin
        w_alu = '0;
        case (alu_op)
            4'd0:    w_alu = w_op_a + w_op_b;
            4'd1:    w_alu = w_op_a - w_op_b;
            4'd2:    w_alu = w_op_a & w_op_b;
            4'd3:    w_alu = w_op_a | w_op_b;
            4'd4:    w_alu = w_op_a ^ w_op_b;
            4'd5:    w_alu = w_op_a << w_shamt;
            4'd6:    w_alu = w_op_a >> w_shamt;
            4'd7:    w_alu = $signed(w_op_a) >>> w_shamt;
            4'd8:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            4'd9:    w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            default: w_alu = '0;
        endcase
    end

    assign in_ready = !w_busy && !flush && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(XLEN);
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_mcand, r_mplier, r_acc, w_acc_nxt;
    logic [6:0]        r_p_ctl;
    logic [REG_AW-1:0] r_p_rd;
    logic [XLEN-1:0]   r_p_store;
    logic [PC_W-1:0]   r_p_pc, r_p_pc_imm;
    logic              w_is_mul, w_mul_done;

    assign w_is_mul   = (alu_op == 4'd10);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_W'(XLEN-1));
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state == S_MUL);
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
                S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand and side-band latches hold the op for the whole iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_p_ctl    <= '0;
            r_p_rd     <= '0;
            r_p_store  <= '0;
            r_p_pc     <= '0;
            r_p_pc_imm <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt      <= '0;
            r_mcand    <= w_op_a;
            r_mplier   <= w_op_b;
            r_acc      <= '0;
            r_p_ctl    <= ctl_in;
            r_p_rd     <= rd_in;
            r_p_store  <= w_op_b_fwd;
            r_p_pc     <= pc_in;
            r_p_pc_imm <= w_pc_imm;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign w_ld        = w_mul_done || (w_accept && !w_is_mul);
    assign w_ld_ctl    = w_mul_done ? r_p_ctl    : ctl_in;
    assign w_ld_rd     = w_mul_done ? r_p_rd     : rd_in;
    assign w_ld_result = w_mul_done ? w_acc_nxt  : w_alu;
    assign w_ld_store  = w_mul_done ? r_p_store  : w_op_b_fwd;
    assign w_ld_pc     = w_mul_done ? r_p_pc     : pc_in;
    assign w_ld_pc_imm = w_mul_done ? r_p_pc_imm : w_pc_imm;
`else
    assign w_busy      = 1'b0;
    assign dbg_state   = 1'b0;
    assign w_ld        = w_accept;
    assign w_ld_ctl    = ctl_in;
    assign w_ld_rd     = rd_in;
    assign w_ld_result = w_alu;
    assign w_ld_store  = w_op_b_fwd;
    assign w_ld_pc     = pc_in;
    assign w_ld_pc_imm = w_pc_imm;
`endif

    // Drain clears valid/ctl; a load on the same edge overrides it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_ctl       <= '0;
            r_rd        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_store     <= '0;
            r_pc        <= '0;
            r_pc_imm    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_ctl       <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_ctl       <= '0;
            end
            if (w_ld) begin
                r_out_valid <= 1'b1;
                r_ctl       <= w_ld_ctl;
                r_rd        <= w_ld_rd;
                r_result    <= w_ld_result;
                r_zero      <= (w_ld_result == '0);
                r_store     <= w_ld_store;
                r_pc        <= w_ld_pc;
                r_pc_imm    <= w_ld_pc_imm;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign ctl_out        = r_ctl;
    assign rd_out         = r_rd;
    assign alu_result_out = r_result;
    assign zero_out       = r_zero;
    assign store_data_out = r_store;
    assign pc_out         = r_pc;
    assign pc_imm_out     = r_pc_imm;
    assign busy           = w_busy;
endmodule
